// File: rtl/sp_instr_scheduler_if.sv
// Bundles the scheduler's instruction, dispatch, acknowledge and status signals.
// master = environment (instruction source and execution units), slave = scheduler.
interface sp_instr_scheduler_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_opcode;
  logic [5:0]  instr_mat;
  logic [31:0] instr_addr;

  logic        ls_req;
  logic        ls_store;
  logic [5:0]  ls_mat;
  logic [31:0] ls_addr;
  logic        ls_ack;

  logic        gemm_req;
  logic        gemm_new_weight;
  logic [5:0]  gemm_out;
  logic [5:0]  gemm_in;
  logic [5:0]  gemm_wt;
  logic [5:0]  gemm_ps;
  logic        gemm_ack;

  logic        idle;
  logic [15:0] stall_cnt;
  logic        spurious_ack;

  modport master (
    output instr_valid, instr_opcode, instr_mat, instr_addr, ls_ack, gemm_ack,
    input  instr_ready, ls_req, ls_store, ls_mat, ls_addr,
    input  gemm_req, gemm_new_weight, gemm_out, gemm_in, gemm_wt, gemm_ps,
    input  idle, stall_cnt, spurious_ack
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_mat, instr_addr, ls_ack, gemm_ack,
    output instr_ready, ls_req, ls_store, ls_mat, ls_addr,
    output gemm_req, gemm_new_weight, gemm_out, gemm_in, gemm_wt, gemm_ps,
    output idle, stall_cnt, spurious_ack
  );
endinterface

// File: rtl/sp_instr_scheduler.sv
// In-order single-head scheduler dispatching load/store and GEMM work to two units,
// holding back any instruction whose scratchpad matrices collide with the other unit's in-flight op.
module sp_instr_scheduler (
  input logic                  CLK,
  input logic                  RST,
  sp_instr_scheduler_if.slave  bus
);

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_GEMM  = 2'd3;

  typedef enum logic {LS_FREE, LS_BUSY} lsState_t;
  typedef enum logic {GM_FREE, GM_BUSY} gmState_t;

  lsState_t    r_lsState;
  gmState_t    r_gmState;

  logic        r_headValid;
  logic [1:0]  r_headOp;
  logic [5:0]  r_headMat;
  logic [31:0] r_headAddr;

  logic        r_lsStore;
  logic [5:0]  r_lsMat;
  logic [31:0] r_lsAddr;

  logic        r_gmNewWeight;
  logic [5:0]  r_gmOut;
  logic [5:0]  r_gmIn;
  logic [5:0]  r_gmWt;
  logic [5:0]  r_gmPs;

  logic [15:0] r_stallCnt;
  logic        r_spurious;

  logic [5:0]  w_hOut;
  logic [5:0]  w_hIn;
  logic [5:0]  w_hWt;
  logic [5:0]  w_hPs;
  logic        w_headIsLs;
  logic        w_lsHazard;
  logic        w_gmHazard;
  logic        w_issueLs;
  logic        w_issueGm;
  logic        w_retireNop;
  logic        w_headDone;
  logic        w_ready;

  assign w_hOut = r_headAddr[23:18];
  assign w_hIn  = r_headAddr[17:12];
  assign w_hWt  = r_headAddr[11:6];
  assign w_hPs  = r_headAddr[5:0];

  // A load may not touch any GEMM operand in flight; a store only conflicts with the GEMM output.
  assign w_headIsLs = r_headValid && ((r_headOp == OP_LOAD) || (r_headOp == OP_STORE));
  assign w_lsHazard = (r_gmState == GM_BUSY) &&
                      ((r_headOp == OP_LOAD) ?
                         ((r_headMat == r_gmOut) || (r_headMat == r_gmIn) ||
                          (r_headMat == r_gmWt)  || (r_headMat == r_gmPs)) :
                         (r_headMat == r_gmOut));
  assign w_gmHazard = (r_lsState == LS_BUSY) &&
                      (r_lsStore ?
                         (r_lsMat == w_hOut) :
                         ((r_lsMat == w_hOut) || (r_lsMat == w_hIn) ||
                          (r_lsMat == w_hWt)  || (r_lsMat == w_hPs)));

  assign w_issueLs   = !RST && w_headIsLs && (r_lsState == LS_FREE) && !w_lsHazard;
  assign w_issueGm   = !RST && r_headValid && (r_headOp == OP_GEMM) &&
                       (r_gmState == GM_FREE) && !w_gmHazard;
  assign w_retireNop = !RST && r_headValid && (r_headOp == OP_NOP);
  assign w_headDone  = w_issueLs || w_issueGm || w_retireNop;
  assign w_ready     = !RST && (!r_headValid || w_headDone);

  assign bus.instr_ready = w_ready;
  assign bus.idle        = !r_headValid && (r_lsState == LS_FREE) && (r_gmState == GM_FREE);
  assign bus.stall_cnt   = RST ? 16'd0 : r_stallCnt;
  assign bus.spurious_ack = RST ? 1'b0 : r_spurious;

  // Operands are presented from the head in the issue cycle, then held from the in-flight copy.
  assign bus.ls_req          = w_issueLs;
  assign bus.ls_store        = RST ? 1'b0  : (w_issueLs ? (r_headOp == OP_STORE) : r_lsStore);
  assign bus.ls_mat          = RST ? 6'd0  : (w_issueLs ? r_headMat  : r_lsMat);
  assign bus.ls_addr         = RST ? 32'd0 : (w_issueLs ? r_headAddr : r_lsAddr);
  assign bus.gemm_req        = w_issueGm;
  assign bus.gemm_new_weight = RST ? 1'b0 : (w_issueGm ? r_headMat[5] : r_gmNewWeight);
  assign bus.gemm_out        = RST ? 6'd0 : (w_issueGm ? w_hOut : r_gmOut);
  assign bus.gemm_in         = RST ? 6'd0 : (w_issueGm ? w_hIn  : r_gmIn);
  assign bus.gemm_wt         = RST ? 6'd0 : (w_issueGm ? w_hWt  : r_gmWt);
  assign bus.gemm_ps         = RST ? 6'd0 : (w_issueGm ? w_hPs  : r_gmPs);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_headValid   <= 1'b0;
      r_headOp      <= OP_NOP;
      r_headMat     <= 6'd0;
      r_headAddr    <= 32'd0;
      r_lsState     <= LS_FREE;
      r_lsStore     <= 1'b0;
      r_lsMat       <= 6'd0;
      r_lsAddr      <= 32'd0;
      r_gmState     <= GM_FREE;
      r_gmNewWeight <= 1'b0;
      r_gmOut       <= 6'd0;
      r_gmIn        <= 6'd0;
      r_gmWt        <= 6'd0;
      r_gmPs        <= 6'd0;
      r_stallCnt    <= 16'd0;
      r_spurious    <= 1'b0;
    end else begin
      if (bus.instr_valid && w_ready) begin
        r_headValid <= 1'b1;
        r_headOp    <= bus.instr_opcode;
        r_headMat   <= bus.instr_mat;
        r_headAddr  <= bus.instr_addr;
      end else if (w_headDone) begin
        r_headValid <= 1'b0;
      end

      // An ack reaching a free unit is flagged; issue needs FREE so it cannot collide with a real ack.
      if (r_lsState == LS_FREE) begin
        if (bus.ls_ack) r_spurious <= 1'b1;
        if (w_issueLs) begin
          r_lsState <= LS_BUSY;
          r_lsStore <= (r_headOp == OP_STORE);
          r_lsMat   <= r_headMat;
          r_lsAddr  <= r_headAddr;
        end
      end else if (bus.ls_ack) begin
        r_lsState <= LS_FREE;
      end

      if (r_gmState == GM_FREE) begin
        if (bus.gemm_ack) r_spurious <= 1'b1;
        if (w_issueGm) begin
          r_gmState     <= GM_BUSY;
          r_gmNewWeight <= r_headMat[5];
          r_gmOut       <= w_hOut;
          r_gmIn        <= w_hIn;
          r_gmWt        <= w_hWt;
          r_gmPs        <= w_hPs;
        end
      end else if (bus.gemm_ack) begin
        r_gmState <= GM_FREE;
      end

      if (r_headValid && !w_headDone && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sp_instr_scheduler.sv
// Directed and randomized bench for sp_instr_scheduler; emulates both execution units
// and compares every cycle against a queue-based model of the scheduling rules.
module tb_sp_instr_scheduler;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  mat;
    logic [31:0] addr;
  } instr_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sp_instr_scheduler_if bus ();

  sp_instr_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int testsRun;
  int testsFailed;

  instr_t prog[$];
  bit     rstNow, gapNow, injLsAck, injGmAck;
  int     lsLat, gmLat, lsCount, gmCount;

  bit          mHeadValid, mLsBusy, mGmBusy, mSpur, mLsStore, mGmNw;
  instr_t      mHead;
  logic [5:0]  mLsMat;
  logic [31:0] mLsAddr;
  logic [23:0] mGmFields;
  int          mStall;

  logic [31:0] gAddr;
  int          stallBase;

  function automatic instr_t mkInstr(logic [1:0] op, logic [5:0] mat, logic [31:0] addr);
    instr_t t;
    t.op = op;
    t.mat = mat;
    t.addr = addr;
    return t;
  endfunction

  function automatic bit matInGemm(logic [5:0] m, logic [23:0] f);
    return (m == f[23:18]) || (m == f[17:12]) || (m == f[11:6]) || (m == f[5:0]);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus();
    bit lsAckNow, gmAckNow, vld;
    bit isLoad, isStore, isGemm, isNop, lsBlock, gmBlock;
    bit expLs, expGm, expDone, expReady, expIdle;
    bit eLsStore, eGmNw;
    logic [5:0]  eLsMat;
    logic [31:0] eLsAddr;
    logic [23:0] eGmFields;

    lsAckNow = (lsCount == 1) || injLsAck;
    gmAckNow = (gmCount == 1) || injGmAck;
    if (lsCount > 0) lsCount--;
    if (gmCount > 0) gmCount--;
    vld = (prog.size() > 0) && !gapNow;

    RST = rstNow;
    bus.instr_valid = vld;
    if (vld) begin
      bus.instr_opcode = prog[0].op;
      bus.instr_mat    = prog[0].mat;
      bus.instr_addr   = prog[0].addr;
    end else begin
      bus.instr_opcode = 2'($urandom);
      bus.instr_mat    = 6'($urandom);
      bus.instr_addr   = $urandom;
    end
    bus.ls_ack   = lsAckNow;
    bus.gemm_ack = gmAckNow;

    @(negedge CLK);
    isLoad  = mHeadValid && (mHead.op == 2'd1);
    isStore = mHeadValid && (mHead.op == 2'd2);
    isGemm  = mHeadValid && (mHead.op == 2'd3);
    isNop   = mHeadValid && (mHead.op == 2'd0);
    lsBlock = mGmBusy && (isLoad ? matInGemm(mHead.mat, mGmFields) : (mHead.mat == mGmFields[23:18]));
    gmBlock = mLsBusy && (mLsStore ? (mLsMat == mHead.addr[23:18]) : matInGemm(mLsMat, mHead.addr[23:0]));
    expLs    = !rstNow && (isLoad || isStore) && !mLsBusy && !lsBlock;
    expGm    = !rstNow && isGemm && !mGmBusy && !gmBlock;
    expDone  = expLs || expGm || isNop;
    expReady = !rstNow && (!mHeadValid || expDone);
    expIdle  = !mHeadValid && !mLsBusy && !mGmBusy;

    eLsStore  = expLs ? isStore    : mLsStore;
    eLsMat    = expLs ? mHead.mat  : mLsMat;
    eLsAddr   = expLs ? mHead.addr : mLsAddr;
    eGmNw     = expGm ? mHead.mat[5]      : mGmNw;
    eGmFields = expGm ? mHead.addr[23:0]  : mGmFields;
    if (rstNow) begin
      eLsStore = 1'b0; eLsMat = '0; eLsAddr = '0; eGmNw = 1'b0; eGmFields = '0;
    end

    checkOutput("instr_ready", 32'(bus.instr_ready), 32'(expReady));
    checkOutput("ls_req", 32'(bus.ls_req), 32'(expLs));
    checkOutput("gemm_req", 32'(bus.gemm_req), 32'(expGm));
    checkOutput("ls_store", 32'(bus.ls_store), 32'(eLsStore));
    checkOutput("ls_mat", 32'(bus.ls_mat), 32'(eLsMat));
    checkOutput("ls_addr", bus.ls_addr, eLsAddr);
    checkOutput("gemm_new_weight", 32'(bus.gemm_new_weight), 32'(eGmNw));
    checkOutput("gemm_fields", 32'({bus.gemm_out, bus.gemm_in, bus.gemm_wt, bus.gemm_ps}), 32'(eGmFields));
    checkOutput("idle", 32'(bus.idle), 32'(expIdle));
    checkOutput("stall_cnt", 32'(bus.stall_cnt), rstNow ? 32'd0 : 32'(mStall));
    checkOutput("spurious_ack", 32'(bus.spurious_ack), rstNow ? 32'd0 : 32'(mSpur));

    @(posedge CLK);
    if (rstNow) begin
      mHeadValid = 0; mLsBusy = 0; mGmBusy = 0; mSpur = 0; mStall = 0;
      mLsStore = 0; mLsMat = '0; mLsAddr = '0; mGmNw = 0; mGmFields = '0;
    end else begin
      if (lsAckNow) begin
        if (mLsBusy) mLsBusy = 0; else mSpur = 1;
      end
      if (gmAckNow) begin
        if (mGmBusy) mGmBusy = 0; else mSpur = 1;
      end
      if (expLs) begin
        mLsBusy = 1; mLsStore = isStore; mLsMat = mHead.mat; mLsAddr = mHead.addr;
        lsCount = lsLat;
      end
      if (expGm) begin
        mGmBusy = 1; mGmNw = mHead.mat[5]; mGmFields = mHead.addr[23:0];
        gmCount = gmLat;
      end
      if (mHeadValid && !expDone && (mStall < 65535)) mStall++;
      if (expDone) mHeadValid = 0;
      if (vld && expReady) begin
        mHead = prog.pop_front();
        mHeadValid = 1;
      end
    end
    #1;
  endtask

  task automatic runUntilIdle(int maxCycles, string tag);
    int n;
    n = 0;
    while ((prog.size() > 0 || mHeadValid || mLsBusy || mGmBusy) && (n < maxCycles)) begin
      applyStimulus();
      n++;
    end
    testsRun++;
    assert (n < maxCycles) else begin
      testsFailed++;
      $error("[TB] FAIL %s timeout: observed %0d cycles, expected fewer than %0d", tag, n, maxCycles);
    end
  endtask

  initial begin
    testsRun = 0; testsFailed = 0;
    rstNow = 1; gapNow = 0; injLsAck = 0; injGmAck = 0;
    lsLat = 10; gmLat = 20; lsCount = 0; gmCount = 0;
    mHeadValid = 0; mLsBusy = 0; mGmBusy = 0; mSpur = 0; mStall = 0;
    mLsStore = 0; mLsMat = '0; mLsAddr = '0; mGmNw = 0; mGmFields = '0; mHead = '0;
    gAddr = {8'h00, 6'h35, 6'h15, 6'h25, 6'h05};
    RST = 1'b1;
    bus.instr_valid = 1'b0; bus.instr_opcode = '0; bus.instr_mat = '0; bus.instr_addr = '0;
    bus.ls_ack = 1'b0; bus.gemm_ack = 1'b0;
    @(posedge CLK); #1;

    repeat (3) applyStimulus();
    rstNow = 0;
    RST = 1'b0;
    #1;
    checkOutput("post_reset_idle", 32'(bus.idle), 32'd1);
    checkOutput("post_reset_ready", 32'(bus.instr_ready), 32'd1);

    // Three independent loads, each offered once the unit has drained.
    prog.push_back(mkInstr(2'd1, 6'h25, 32'd4));
    runUntilIdle(100, "load_a");
    prog.push_back(mkInstr(2'd1, 6'h15, 32'd36));
    runUntilIdle(100, "load_b");
    prog.push_back(mkInstr(2'd1, 6'h05, 32'd68));
    runUntilIdle(100, "load_c");
    checkOutput("load_seq_stall", 32'(bus.stall_cnt), 32'd0);
    checkOutput("load_seq_mat_hold", 32'(bus.ls_mat), 32'h05);
    checkOutput("load_seq_addr_hold", bus.ls_addr, 32'd68);

    // GEMM followed by an unrelated load that overlaps it.
    prog.push_back(mkInstr(2'd3, 6'h20, gAddr));
    prog.push_back(mkInstr(2'd1, 6'h07, 32'd132));
    runUntilIdle(200, "gemm_load");
    checkOutput("gemm_nw_hold", 32'(bus.gemm_new_weight), 32'd1);
    checkOutput("gemm_out_hold", 32'(bus.gemm_out), 32'h35);
    checkOutput("gemm_in_hold", 32'(bus.gemm_in), 32'h15);
    checkOutput("gemm_wt_hold", 32'(bus.gemm_wt), 32'h25);
    checkOutput("gemm_ps_hold", 32'(bus.gemm_ps), 32'h05);
    checkOutput("gemm_load_mat", 32'(bus.ls_mat), 32'h07);
    checkOutput("gemm_load_stall", 32'(bus.stall_cnt), 32'd0);

    // Store to the GEMM output waits for the whole GEMM latency.
    stallBase = mStall;
    prog.push_back(mkInstr(2'd3, 6'h20, gAddr));
    prog.push_back(mkInstr(2'd2, 6'h35, 32'd100));
    runUntilIdle(200, "store_hazard");
    checkOutput("store_hazard_stalls", 32'(bus.stall_cnt), 32'(stallBase + 20));
    checkOutput("store_flag_hold", 32'(bus.ls_store), 32'd1);

    // Load of the weight matrix stalls, and the NOP behind it waits too.
    stallBase = mStall;
    prog.push_back(mkInstr(2'd3, 6'h00, gAddr));
    prog.push_back(mkInstr(2'd1, 6'h25, 32'h0000_1000));
    prog.push_back(mkInstr(2'd0, 6'h00, 32'd0));
    runUntilIdle(200, "load_wt_hazard");
    checkOutput("load_wt_stalls", 32'(bus.stall_cnt), 32'(stallBase + 20));

    // Spurious GEMM ack while free, then reset in the middle of a GEMM.
    injGmAck = 1;
    applyStimulus();
    injGmAck = 0;
    checkOutput("spurious_set", 32'(bus.spurious_ack), 32'd1);
    checkOutput("spurious_no_busy", 32'(bus.idle), 32'd1);
    gmLat = 30;
    prog.push_back(mkInstr(2'd3, 6'h20, gAddr));
    repeat (5) applyStimulus();
    rstNow = 1;
    applyStimulus();
    rstNow = 0;
    RST = 1'b0;
    #1;
    checkOutput("rst_mid_idle", 32'(bus.idle), 32'd1);
    checkOutput("rst_mid_gemm_req", 32'(bus.gemm_req), 32'd0);
    checkOutput("rst_mid_gemm_out", 32'(bus.gemm_out), 32'd0);
    checkOutput("rst_mid_spurious", 32'(bus.spurious_ack), 32'd0);
    repeat (30) applyStimulus();
    checkOutput("stale_ack_spurious", 32'(bus.spurious_ack), 32'd1);

    // Back-to-back loads: the waiting load issues the cycle after the ack.
    lsLat = 5;
    prog.push_back(mkInstr(2'd1, 6'h01, 32'h10));
    prog.push_back(mkInstr(2'd1, 6'h02, 32'h20));
    runUntilIdle(100, "back_to_back");
    lsLat = 1;
    for (int i = 0; i < 4; i++) prog.push_back(mkInstr(2'd2, 6'(i), 32'(i * 8)));
    runUntilIdle(100, "single_cycle_ls");

    // Random traffic over a small matrix-ID space so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      if ((prog.size() < 4) && ($urandom_range(0, 1) == 0)) begin
        logic [1:0]  op;
        logic [5:0]  mat;
        logic [31:0] addr;
        op = 2'($urandom_range(0, 3));
        if (op == 2'd3) begin
          mat  = 6'($urandom);
          addr = {8'($urandom), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                  6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
        end else begin
          mat  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
          addr = $urandom;
        end
        prog.push_back(mkInstr(op, mat, addr));
      end
      lsLat    = $urandom_range(1, 8);
      gmLat    = $urandom_range(1, 12);
      gapNow   = ($urandom_range(0, 3) == 0);
      injLsAck = ($urandom_range(0, 80) == 0);
      injGmAck = ($urandom_range(0, 80) == 0);
      rstNow   = ($urandom_range(0, 400) == 0);
      applyStimulus();
    end
    gapNow = 0; injLsAck = 0; injGmAck = 0; rstNow = 0;
    runUntilIdle(600, "random_drain");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
